uart_tx_ctrl: RTL and testbench

//   Transmit sequencer for the UART. Consumes the en_tx pulse stream from the baud divisor
//   (16 pulses per bit time) and serialises bytes from a small internal FIFO onto tx.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_tx_ctrl_if.sv | 9 +
 rtl/uart_tx_fifo.sv | 38 +++
 rtl/uart_tx_ctrl.sv | 114 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: oversampling and frame constants plus FSM state encoding shared by the UART controllers
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: CPU-side byte write handshake into the transmit controller
interface uart_tx_ctrl_if;
    import uart_pkg::*;
    logic [DATA_BITS-1:0] wr_data;
    logic wr_valid;
    logic wr_ready;
    modport master (output wr_data, wr_valid, input wr_ready);
    modport slave (input wr_data, wr_valid, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with registered pointers and occupancy count
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    // storage carries no reset; only entries below level are ever read
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
    assign dout = mem[rp];
    assign full = level == (AW + 1)'(DEPTH);
    assign empty = level == '0;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer; optional parity bit enabled by defining UART_TX_PARITY_EN
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_tx,
    uart_tx_ctrl_if.slave                 wr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done
);
    uart_state_e state, state_d;
    logic [3:0] tick, tick_d;
    logic [2:0] bit_cnt, bit_d;
    logic [DATA_BITS-1:0] shift, shift_d, head;
    logic par, par_d, tx_d, done_d, pop, push, full, empty, bit_end;

    assign push = wr.wr_valid && !full;
    assign wr.wr_ready = !full;
    assign busy = state != IDLE || !empty;
    assign bit_end = en_tx && tick == 4'(OVERSAMPLE - 1);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(wr.wr_data),
        .dout(head), .full(full), .empty(empty), .level(fifo_level)
    );

    // next state, bit timing and line level; a pop always (re)starts a frame
    always_comb begin
        state_d = state;
        tick_d = en_tx ? tick + 4'd1 : tick;
        bit_d = bit_cnt;
        shift_d = shift;
        par_d = par;
        pop = 1'b0;
        done_d = 1'b0;
        case (state)
            IDLE: pop = en_tx && !empty;
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift >> 1;
                    bit_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                        bit_d = '0;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        pop = !empty;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d = START;
            tick_d = '0;
            shift_d = head;
            par_d = ^head ^ 1'(PARITY_ODD);
        end
        tx_d = state_d == START ? 1'b0 :
               state_d == DATA ? shift_d[0] :
               state_d == PARITY ? par_d : 1'b1;
    end

    // state and registered outputs; reset drops any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tick <= '0;
            bit_cnt <= '0;
            shift <= '0;
            par <= 1'b0;
            tx <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state <= state_d;
            tick <= tick_d;
            bit_cnt <= bit_d;
            shift <= shift_d;
            par <= par_d;
            tx <= tx_d;
            tx_done <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: frame-level model check of two uart_tx_ctrl builds (1 stop/even, 2 stop/odd)
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en_tx = 1'b0;
    logic wr_valid = 1'b0;
    logic tick_on = 1'b0;
    logic [7:0] wr_data = 8'h00;
    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // en_tx: one pulse every 4 clocks while enabled
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            en_tx = tick_on && (c % 4 == 0);
            c++;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int NB = 10 + PB + g;
        uart_tx_ctrl_if bus();
        logic [2:0] fifo_level;
        logic tx, busy, tx_done;
        byte unsigned q[$];
        logic [11:0] frame = '1;
        int tpos = 0;
        bit active = 1'b0;
        bit m_done = 1'b0;
        logic m_tx = 1'b1;

        assign bus.wr_data = wr_data;
        assign bus.wr_valid = wr_valid;

        uart_tx_ctrl #(.FIFO_DEPTH(FD), .STOP_BITS(g + 1), .PARITY_ODD(g)) dut (
            .clk(clk), .rst(rst), .en_tx(en_tx), .wr(bus),
            .fifo_level(fifo_level), .tx(tx), .busy(busy), .tx_done(tx_done)
        );

        // model: a frame is a bit list, each bit held for 16 en_tx pulses
        always @(posedge clk or negedge rst) begin
            int n;
            byte unsigned b;
            if (!rst) begin
                q.delete();
                active = 1'b0;
                tpos = 0;
                m_done = 1'b0;
                m_tx = 1'b1;
            end else begin
                n = q.size();
                m_done = 1'b0;
                if (en_tx && active) begin
                    tpos++;
                    if (tpos == NB * 16) begin
                        active = 1'b0;
                        m_done = 1'b1;
                    end
                end
                if (en_tx && !active && n > 0) begin
                    b = q.pop_front();
                    frame = '1;
                    frame[8:0] = {b, 1'b0};
                    if (PB == 1) frame[9] = (^b) ^ (g == 1);
                    active = 1'b1;
                    tpos = 0;
                end
                if (wr_valid && n < FD) q.push_back(wr_data);
                m_tx = active ? frame[tpos / 16] : 1'b1;
            end
        end

        always @(negedge clk) begin
            if (chk_on) begin
                chk("tx", g, tx, m_tx);
                chk("tx_done", g, tx_done, m_done);
                chk("busy", g, busy, active || q.size() != 0);
                chk("fifo_level", g, fifo_level, q.size());
                chk("wr_ready", g, bus.wr_ready, q.size() < FD);
            end
        end
    end

    task automatic write_byte(input logic [7:0] b);
        wr_data = b;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((u[0].busy || u[1].busy) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_in_time", 0, k < 5000, 1);
    endtask

    // samples mid-bit values of both lines, start-bit width and first tx_done position of instance 0
    task automatic capture(output logic [11:0] a, output logic [11:0] b, output int low, output int dpos);
        bit seen;
        a = '1;
        b = '1;
        low = 0;
        dpos = -1;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            seen = u[0].tx == 1'b0;
        end
        chk("start_seen", 0, seen, 1);
        for (int c = 0; c < 12 * 64; c++) begin
            if (c % 64 == 32) begin
                a[c / 64] = u[0].tx;
                b[c / 64] = u[1].tx;
            end
            if (u[0].tx == 1'b0 && c == low) low++;
            if (u[0].tx_done && dpos < 0) dpos = c;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [11:0] s0, s1;
        int low, dpos, n0, n1, run0, run1, r0, r1, ones;
        int d0[4];
        int d1[4];
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_on = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_tx", 0, u[0].tx, 1);
        chk("reset_ready", 0, u[0].bus.wr_ready, 1);
        chk("reset_busy", 0, u[0].busy, 0);

        // asynchronous reset with a byte queued: outputs clear in the same cycle
        write_byte(8'hA5);
        chk("queued_level", 0, u[0].fifo_level, 1);
        chk("queued_busy", 0, u[0].busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_tx", 0, u[0].tx, 1);
        chk("async_ready", 0, u[0].bus.wr_ready, 1);
        chk("async_busy", 0, u[0].busy, 0);
        chk("async_level", 0, u[0].fifo_level, 0);
        @(negedge clk);
        rst = 1'b1;
        tick_on = 1'b1;
        ones = 0;
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            ones += u[0].tx;
        end
        chk("nothing_sent", 0, ones, 800);

        // 0x55, 10-bit frame, 64 clk per bit
        write_byte(8'h55);
        capture(s0, s1, low, dpos);
        chk("frame55", 0, s0[9:0], PB ? 10'h0AA : 10'h2AA);
        chk("start_width", 0, low, 64);
        chk("done_pos", 0, dpos, 64 * (10 + PB));
        wait_idle();

        // 0x07: parity bit value (or stop bit when parity is absent)
        write_byte(8'h07);
        capture(s0, s1, low, dpos);
        chk("frame07_data", 0, s0[8:0], 9'h00E);
        chk("frame07_bit9", 0, s0[9], 1);
        chk("frame07_bit9", 1, s1[9], PB ? 0 : 1);
        chk("frame07_len", 0, dpos, 64 * (10 + PB));
        wait_idle();

        // fill with ticks frozen: 4 of 5 accepted, then contiguous frames
        tick_on = 1'b0;
        repeat (4) @(negedge clk);
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'h10 + 8'(i * 17);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("full_level", 0, u[0].fifo_level, 4);
        chk("full_ready", 0, u[0].bus.wr_ready, 0);
        chk("full_level", 1, u[1].fifo_level, 4);
        tick_on = 1'b1;
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 5000 && (n0 < 4 || n1 < 4); c++) begin
            @(negedge clk);
            if (u[0].tx_done && n0 < 4) begin d0[n0] = c; n0++; end
            if (u[1].tx_done && n1 < 4) begin d1[n1] = c; n1++; end
        end
        chk("done_count", 0, n0, 4);
        chk("done_count", 1, n1, 4);
        if (n0 == 4) chk("b2b_period", 0, d0[3] - d0[2], 64 * (10 + PB));
        if (n1 == 4) chk("b2b_period", 1, d1[1] - d1[0], 64 * (11 + PB));
        wait_idle();

        // reset in the middle of data bit 3, then a clean frame
        write_byte(8'h3C);
        r0 = 0;
        for (int k = 0; k < 3000 && u[0].tx; k++) @(negedge clk);
        repeat (64 * 4 + 32) @(negedge clk);
        chk("mid_busy", 0, u[0].busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_tx", 0, u[0].tx, 1);
        chk("midrst_tx", 1, u[1].tx, 1);
        chk("midrst_busy", 0, u[0].busy, 0);
        chk("midrst_level", 0, u[0].fifo_level, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        write_byte(8'hC3);
        capture(s0, s1, low, dpos);
        chk("clean_frame", 0, s0[8:0], 9'h186);
        chk("clean_start", 0, low, 64);
        wait_idle();

        // two queued bytes: stop-high run before the second start bit
        tick_on = 1'b0;
        repeat (4) @(negedge clk);
        write_byte(8'h01);
        write_byte(8'h33);
        tick_on = 1'b1;
        run0 = 0;
        run1 = 0;
        r0 = -1;
        r1 = -1;
        for (int c = 0; c < 5000 && (r0 < 0 || r1 < 0); c++) begin
            @(negedge clk);
            if (u[0].tx) run0++; else if (u[0].tx_done && r0 < 0) r0 = run0; else run0 = 0;
            if (u[1].tx) run1++; else if (u[1].tx_done && r1 < 0) r1 = run1; else run1 = 0;
        end
        chk("stop_run", 0, r0, 64 * (1 + PB));
        chk("stop_run", 1, r1, 128);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
